// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command decoder driving SD reader restart, status reply and file-byte streaming
// Bytes to UART TX come from a 5-byte status message or a file-byte FIFO whose head is offered in place.
module uart_cmd_ctrl #(
   parameter int RST_CYCLES = 16,
   parameter int FIFO_ASIZE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       sd_rst_n,
   input  logic [1:0] sd_type,
   input  logic [1:0] fs_type,
   input  logic       file_found,
   input  logic       file_req,
   input  logic [7:0] file_byte,
   output logic       tx_req,
   input  logic       tx_gnt,
   output logic [7:0] tx_data,
   output logic       overflow,
   output logic       busy
);

   localparam int DEPTH = 1 << FIFO_ASIZE;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESTART = 2'd1,
      STATUS  = 2'd2
   } state_t;

   state_t                state_q;
   logic [7:0]            cnt_q;
   logic                  sd_rst_n_q;
   logic                  tx_req_q;
   logic [7:0]            tx_data_q;
   logic                  tx_src_msg_q;
   logic                  overflow_q;
   logic [2:0]            msg_idx_q;
   logic [1:0]            cap_sd_q;
   logic [1:0]            cap_fs_q;
   logic                  cap_ff_q;
   logic [FIFO_ASIZE:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_ASIZE:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_ASIZE:0]   rd_ptr_inc;
   logic [7:0]            mem_q [DEPTH];

   logic       cmd_restart, cmd_status;
   logic       fifo_empty, fifo_full;
   logic       tx_free, pop, fifo_has;
   logic       msg_turn, fifo_turn;
   logic       load_msg, load_fifo;
   logic       wr_accept, wr_en, wr_drop;
   logic [7:0] head_byte, msg_byte;

   assign cmd_restart = rx_valid && (rx_data == 8'h72);
   assign cmd_status  = rx_valid && (rx_data == 8'h73) && (state_q == IDLE);

   assign rd_ptr_inc = rd_ptr_q + 1'b1;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_ASIZE] != rd_ptr_q[FIFO_ASIZE]) &&
                       (wr_ptr_q[FIFO_ASIZE-1:0] == rd_ptr_q[FIFO_ASIZE-1:0]);

   // The offered FIFO byte stays at the head and is popped only on its grant.
   assign tx_free  = !tx_req_q || tx_gnt;
   assign pop      = tx_req_q && tx_gnt && !tx_src_msg_q;
   assign fifo_has = pop ? (rd_ptr_inc != wr_ptr_q) : !fifo_empty;
   assign head_byte = pop ? mem_q[rd_ptr_inc[FIFO_ASIZE-1:0]] : mem_q[rd_ptr_q[FIFO_ASIZE-1:0]];

   assign msg_turn  = (state_q == STATUS) && (msg_idx_q < 3'd5);
   assign fifo_turn = (state_q == IDLE) || ((state_q == STATUS) && (msg_idx_q == 3'd5));
   assign load_msg  = tx_free && msg_turn && !cmd_restart;
   assign load_fifo = tx_free && fifo_turn && fifo_has && !cmd_restart;

   assign wr_accept = file_req && !cmd_restart && (state_q != RESTART);
   assign wr_en     = wr_accept && (!fifo_full || pop);
   assign wr_drop   = wr_accept && fifo_full && !pop;

   always_comb begin
      msg_byte = 8'h0A;
      case (msg_idx_q)
         3'd0:    msg_byte = 8'h53;
         3'd1:    msg_byte = 8'h30 + {6'd0, cap_sd_q};
         3'd2:    msg_byte = 8'h30 + {6'd0, cap_fs_q};
         3'd3:    msg_byte = 8'h30 + {7'd0, cap_ff_q};
         default: msg_byte = 8'h0A;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (cmd_restart) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_d = rd_ptr_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_ASIZE-1:0]] <= file_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RESTART;
         cnt_q        <= 8'd0;
         sd_rst_n_q   <= 1'b0;
         tx_req_q     <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_src_msg_q <= 1'b0;
         overflow_q   <= 1'b0;
         msg_idx_q    <= 3'd0;
         cap_sd_q     <= 2'd0;
         cap_fs_q     <= 2'd0;
         cap_ff_q     <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (cmd_restart) begin
            state_q      <= RESTART;
            cnt_q        <= 8'd0;
            sd_rst_n_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_src_msg_q <= 1'b0;
            overflow_q   <= 1'b0;
            msg_idx_q    <= 3'd0;
         end else begin
            if (wr_drop) overflow_q <= 1'b1;
            case (state_q)
               RESTART: begin
                  if (cnt_q == 8'(RST_CYCLES - 1)) begin
                     state_q    <= IDLE;
                     sd_rst_n_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               IDLE: begin
                  if (cmd_status) begin
                     state_q   <= STATUS;
                     msg_idx_q <= 3'd0;
                     cap_sd_q  <= sd_type;
                     cap_fs_q  <= fs_type;
                     cap_ff_q  <= file_found;
                  end
               end
               STATUS: begin
                  if (tx_free && (msg_idx_q == 3'd5)) state_q <= IDLE;
               end
               default: state_q <= RESTART;
            endcase
            if (load_msg) begin
               tx_req_q     <= 1'b1;
               tx_data_q    <= msg_byte;
               tx_src_msg_q <= 1'b1;
               msg_idx_q    <= msg_idx_q + 3'd1;
            end else if (load_fifo) begin
               tx_req_q     <= 1'b1;
               tx_data_q    <= head_byte;
               tx_src_msg_q <= 1'b0;
            end else if (tx_free) begin
               tx_req_q <= 1'b0;
            end
         end
      end
   end

   assign sd_rst_n = sd_rst_n_q;
   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, is the number of clk cycles sd_rst_n is held low per reader restart; legal range 1..255.
REQ-002 Parameter FIFO_ASIZE, default 4, sets the file-byte buffer depth to 2^FIFO_ASIZE bytes.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port rx_valid, input, 1: one-cycle strobe, a received UART byte is on rx_data.
REQ-006 Port rx_data, input, 8: received command byte.
REQ-007 Port sd_rst_n, output, 1: active-low restart to the SD file reader.
REQ-008 Port sd_type, input, 2: card type from the reader (0..3).
REQ-009 Port fs_type, input, 2: filesystem type from the reader (0..3).
REQ-010 Port file_found, input, 1: file-found flag from the reader.
REQ-011 Port file_req, input, 1: one-cycle strobe, file_byte valid; no backpressure on this port.
REQ-012 Port file_byte, input, 8: file content byte.
REQ-013 Port tx_req, output, 1: UART TX write request.
REQ-014 Port tx_gnt, input, 1: UART TX accepts tx_data in the cycle tx_req && tx_gnt.
REQ-015 Port tx_data, output, 8: byte offered to UART TX.
REQ-016 Port overflow, output, 1: sticky, a file byte was dropped.
REQ-017 Port busy, output, 1: high whenever the state machine is not IDLE.

Function
REQ-018 The state machine SHALL have states IDLE, RESTART and STATUS.
REQ-019 Commands SHALL be decoded only on rx_valid: 0x72 ('r') = restart, 0x73 ('s') = status; all other bytes are ignored.
REQ-020 Restart accepted in cycle N: sd_rst_n low from N+1 through N+RST_CYCLES, high at N+RST_CYCLES+1; state RESTART for those cycles, then IDLE.
REQ-021 Restart SHALL flush the FIFO, clear overflow, abort any STATUS message and drop tx_req from N+1, even if a byte is pending without grant.
REQ-022 'r' received during RESTART SHALL restart the RST_CYCLES count.
REQ-023 'r' and file_req in the same cycle: restart wins, the file byte is discarded and overflow is not set.
REQ-024 Status accepted in IDLE SHALL capture sd_type, fs_type, file_found in that cycle and queue the 5-byte message 0x53, 0x30+sd_type, 0x30+fs_type, 0x30+file_found, 0x0A.
REQ-025 's' received in RESTART or STATUS SHALL be ignored.
REQ-026 Handshake: once tx_req rises, tx_req and tx_data SHALL stay constant until the cycle tx_req && tx_gnt (except abort per REQ-021).
REQ-027 After a grant the next byte MAY be presented in the immediately following cycle (back-to-back, one byte per cycle max).
REQ-028 Arbitration: a pending status message has priority over FIFO data, but SHALL NOT preempt a file byte already offered; the message's 5 bytes go out contiguously, then FIFO draining resumes.
REQ-029 With no status message pending and FIFO non-empty, tx_req SHALL rise in the cycle after a byte becomes available (1-cycle FIFO-to-tx latency).
REQ-030 FIFO write on file_req when not full; full and no pop in the same cycle: byte dropped, overflow set to 1.
REQ-031 Full with simultaneous pop (grant of a FIFO byte): the write SHALL be accepted, no overflow.
REQ-032 FIFO pointers SHALL be FIFO_ASIZE+1 bits with wrap-around; full = MSBs differ and the rest are equal; empty = pointers equal.
REQ-033 File bytes SHALL be written to the FIFO during STATUS; they are dropped only during RESTART.

Reset
REQ-034 While rst_n low: sd_rst_n=0, tx_req=0, tx_data=0x00, overflow=0, busy=1, FIFO empty, state RESTART with count cleared.
REQ-035 After rst_n release, sd_rst_n SHALL stay low for RST_CYCLES cycles, then go high with state IDLE (power-up restart of the reader).

Verification
REQ-036 Release reset, RST_CYCLES=16 -> sd_rst_n low 16 cycles after release, then 1; busy 0 afterwards.
REQ-037 sd_type=3, fs_type=3, file_found=1, send 0x73, tx_gnt tied 1 -> tx_data sequence 0x53,0x33,0x33,0x31,0x0A on consecutive cycles.
REQ-038 FIFO_ASIZE=4, tx_gnt=0, 17 file_req strobes -> first 16 held, overflow=1; then tx_gnt=1 -> the 16 bytes come out in order.
REQ-039 File byte offered and stalled (tx_gnt=0), send 's', then grant -> file byte transmitted first, then the 5 status bytes, then the remaining FIFO bytes.
REQ-040 Mid-message after 2 status bytes, send 0x72 -> tx_req 0 next cycle, FIFO empty, overflow 0, sd_rst_n low for RST_CYCLES.
REQ-041 Send 0x41 and 0x72 together with file_req in the same cycle -> 0x41 has no effect; the 0x72 cycle drops the file byte and overflow stays 0.
